pwr_seq_fsm: RTL and testbench

Parametrised power-up/power-down sequencer for gated macros such as MRAM and SRAM banks. It generalises the fixed MRAM power-gate sequence to N programmable steps. Each step has its own run-time dwell count and its own output pattern, and a request reversal mid-ramp unwinds from the current step. It sits between the power-management controller (`power` request) and the macro's supply, retention, reset and isolation pins.

---
 rtl/pwr_seq_pkg.sv | 14 +
 rtl/pwr_seq_fsm_reg_arstn.sv | 17 +
 rtl/pwr_seq_fsm.sv | 126 ++++++++++++
 tb/tb_pwr_seq_fsm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power-gate sequencer.
package pwr_seq_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  // Level-0 control vector: isolate=1, CEb=1, all supplies off.
  localparam logic [9:0] OFF_PATTERN_DEF = 10'b11_0000_0000;

endpackage

// File: rtl/pwr_seq_fsm_reg_arstn.sv
// Plain register with asynchronous active-low reset to a parameterised value.
module reg_arstn #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/pwr_seq_fsm.sv
// N-step power-up/power-down sequencer with per-step dwell and output pattern.
// Handshake: none; power is a level request, done reports the settled target.
module pwr_seq_fsm
  import pwr_seq_pkg::*;
#(
  parameter int               N_STEPS     = 8,
  parameter int               CNT_W       = 8,
  parameter int               OUT_W       = 10,
  parameter logic [OUT_W-1:0] OFF_PATTERN = OUT_W'(OFF_PATTERN_DEF),
  parameter int               LVL_W       = $clog2(N_STEPS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       power,
  input  logic [N_STEPS*CNT_W-1:0]   dwell_i,
  input  logic [N_STEPS*OUT_W-1:0]   pattern_i,
  output logic [OUT_W-1:0]           ctrl_o,
  output logic [LVL_W-1:0]           level_o,
  output logic                       busy,
  output logic                       done
);

  logic [1:0]       state_q;
  state_t           state;
  state_t           state_nxt;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] dwell_sel;
  logic [OUT_W-1:0] ctrl_nxt;

  assign state = state_t'(state_q);

  // Dwell index is level going up and level-1 going down.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    cnt_nxt   = cnt;
    dwell_sel = '0;
    for (int k = 0; k < N_STEPS; k++) begin
      if ((state == ST_RAMP_DOWN && level == LVL_W'(k + 1)) ||
          (state != ST_RAMP_DOWN && level == LVL_W'(k)))
        dwell_sel = dwell_i[k*CNT_W +: CNT_W];
    end
    case (state)
      ST_OFF: begin
        if (power) begin
          state_nxt = ST_RAMP_UP;
          cnt_nxt   = '0;
        end
      end
      ST_RAMP_UP: begin
        if (!power) begin
          state_nxt = ST_RAMP_DOWN;
          cnt_nxt   = '0;
        end else if (level == LVL_W'(N_STEPS)) begin
          // Reached via a reversal right after leaving ON.
          state_nxt = ST_ON;
          cnt_nxt   = '0;
        end else if (cnt == dwell_sel) begin
          level_nxt = level + LVL_W'(1);
          cnt_nxt   = '0;
          if (level == LVL_W'(N_STEPS - 1)) state_nxt = ST_ON;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_ON: begin
        if (!power) begin
          state_nxt = ST_RAMP_DOWN;
          cnt_nxt   = '0;
        end
      end
      ST_RAMP_DOWN: begin
        if (power) begin
          state_nxt = ST_RAMP_UP;
          cnt_nxt   = '0;
        end else if (level == '0) begin
          // Reached via a reversal right after leaving OFF.
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end else if (cnt == dwell_sel) begin
          level_nxt = level - LVL_W'(1);
          cnt_nxt   = '0;
          if (level == LVL_W'(1)) state_nxt = ST_OFF;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_OFF;
        level_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    ctrl_nxt = OFF_PATTERN;
    for (int k = 0; k < N_STEPS; k++) begin
      if (level_nxt == LVL_W'(k + 1)) ctrl_nxt = pattern_i[k*OUT_W +: OUT_W];
    end
  end

  reg_arstn #(.W(2), .RST_VAL(2'(ST_OFF))) u_state_reg (
    .clk(clk), .rst_n(rst), .d(state_nxt), .q(state_q)
  );

  reg_arstn #(.W(LVL_W), .RST_VAL('0)) u_level_reg (
    .clk(clk), .rst_n(rst), .d(level_nxt), .q(level)
  );

  reg_arstn #(.W(CNT_W), .RST_VAL('0)) u_cnt_reg (
    .clk(clk), .rst_n(rst), .d(cnt_nxt), .q(cnt)
  );

  reg_arstn #(.W(OUT_W), .RST_VAL(OFF_PATTERN)) u_ctrl_reg (
    .clk(clk), .rst_n(rst), .d(ctrl_nxt), .q(ctrl_o)
  );

  assign level_o = level;
  assign busy    = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);
  assign done    = (power && state == ST_ON) || (!power && state == ST_OFF);

endmodule

// File: tb/tb_pwr_seq_fsm.sv
// Directed checks on a 4-step sequencer, then randomized power requests on an
// 8-step sequencer checked against a level/direction reference model.
module tb_pwr_seq_fsm;

  localparam int CW = 8;
  localparam int OW = 10;
  localparam int NA = 4;
  localparam int NB = 8;
  localparam logic [OW-1:0] OFFP = 10'b11_0000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              power_a = 1'b0;
  logic [NA*CW-1:0]  dwell_a;
  logic [NA*OW-1:0]  pattern_a;
  logic [OW-1:0]     ctrl_a;
  logic [2:0]        level_a;
  logic              busy_a;
  logic              done_a;

  logic              power_b = 1'b0;
  logic [NB*CW-1:0]  dwell_b;
  logic [NB*OW-1:0]  pattern_b;
  logic [OW-1:0]     ctrl_b;
  logic [3:0]        level_b;
  logic              busy_b;
  logic              done_b;

  pwr_seq_fsm #(.N_STEPS(NA), .CNT_W(CW), .OUT_W(OW)) u_dut_a (
    .clk(clk), .rst(rst), .power(power_a), .dwell_i(dwell_a),
    .pattern_i(pattern_a), .ctrl_o(ctrl_a), .level_o(level_a),
    .busy(busy_a), .done(done_a)
  );

  pwr_seq_fsm #(.N_STEPS(NB), .CNT_W(CW), .OUT_W(OW)) u_dut_b (
    .clk(clk), .rst(rst), .power(power_b), .dwell_i(dwell_b),
    .pattern_i(pattern_b), .ctrl_o(ctrl_b), .level_o(level_b),
    .busy(busy_b), .done(done_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // directed config: dwell k = k, patterns 1,3,7,F
  int da[NA] = '{0, 1, 2, 3};

  function automatic int up_level(input int k);
    int cum = 0;
    int lvl = 0;
    for (int j = 0; j < NA; j++) begin
      cum += da[j] + 1;
      if (cum <= k) lvl++;
    end
    return lvl;
  endfunction

  function automatic int down_level(input int k);
    int cum = 0;
    int lvl = NA;
    for (int j = NA - 1; j >= 0; j--) begin
      cum += da[j] + 1;
      if (cum <= k) lvl--;
    end
    return lvl;
  endfunction

  function automatic logic [OW-1:0] pat_a(input int lvl);
    logic [OW-1:0] tbl[NA] = '{10'h001, 10'h003, 10'h007, 10'h00F};
    return (lvl == 0) ? OFFP : tbl[lvl-1];
  endfunction

  // reference model for dut_b: level, direction (+1/-1/0) and dwell progress
  int            m_level = 0;
  int            m_dir   = 0;
  int            m_cnt   = 0;
  int            m_dw[NB];
  logic [OW-1:0] m_pat[NB];

  task automatic model_step(input logic p);
    int want;
    int edge_lvl;
    want = p ? 1 : -1;
    if (m_dir == 0) begin
      if (p && m_level == 0)        begin m_dir = 1;  m_cnt = 0; end
      else if (!p && m_level == NB) begin m_dir = -1; m_cnt = 0; end
    end else if (want != m_dir) begin
      m_dir = want;
      m_cnt = 0;
    end else begin
      edge_lvl = (m_dir > 0) ? NB : 0;
      if (m_level == edge_lvl) begin
        m_dir = 0;
        m_cnt = 0;
      end else if (m_cnt == m_dw[(m_dir > 0) ? m_level : m_level - 1]) begin
        m_level += m_dir;
        m_cnt = 0;
        if (m_level == 0 || m_level == NB) m_dir = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  initial begin
    dwell_a   = {8'd3, 8'd2, 8'd1, 8'd0};
    pattern_a = {10'h00F, 10'h007, 10'h003, 10'h001};
    dwell_b   = '0;
    for (int k = 0; k < NB; k++) begin
      m_dw[k]  = 0;
      m_pat[k] = OW'($urandom_range(0, 1023));
      pattern_b[k*OW +: OW] = m_pat[k];
    end

    // reset held with power requested
    power_a = 1'b1;
    #1 rst = 1'b0;
    tick();
    tick();
    check("rst_ctrl", ctrl_a, OFFP);
    check("rst_level", level_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done_pwr1", done_a, 0);
    power_a = 1'b0;
    rst = 1'b1;
    tick();
    check("rel_done_pwr0", done_a, 1);
    check("rel_level", level_a, 0);

    // power-up 0..4
    power_a = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      check($sformatf("up_level_e%0d", k), level_a, up_level(k));
      check($sformatf("up_ctrl_e%0d", k), ctrl_a, pat_a(up_level(k)));
      check($sformatf("up_busy_e%0d", k), busy_a, (k < 10));
      check($sformatf("up_done_e%0d", k), done_a, (k == 10));
    end
    tick();
    check("on_hold_level", level_a, NA);
    check("on_hold_done", done_a, 1);

    // power-down 4..0, mirrored dwell order
    power_a = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      tick();
      check($sformatf("dn_level_e%0d", k), level_a, down_level(k));
      check($sformatf("dn_ctrl_e%0d", k), ctrl_a, pat_a(down_level(k)));
      check($sformatf("dn_busy_e%0d", k), busy_a, (k < 10));
      check($sformatf("dn_done_e%0d", k), done_a, (k == 10));
    end

    // reversal at level 2, cnt 1
    power_a = 1'b1;
    for (int k = 0; k <= 4; k++) tick();
    check("rev_pre_level", level_a, 2);
    power_a = 1'b0;
    tick();
    check("rev_edge_level", level_a, 2);
    check("rev_edge_busy", busy_a, 1);
    check("rev_edge_done", done_a, 0);
    tick();
    check("rev_dwell_level", level_a, 2);
    tick();
    check("rev_step_level", level_a, 1);
    check("rev_step_ctrl", ctrl_a, 10'h001);
    tick();
    check("rev_off_level", level_a, 0);
    check("rev_off_done", done_a, 1);
    check("rev_off_ctrl", ctrl_a, OFFP);

    // async reset at level 3, before the next clock edge
    power_a = 1'b1;
    for (int k = 0; k <= 6; k++) tick();
    check("ar_pre_level", level_a, 3);
    #2 rst = 1'b0;
    #1;
    check("ar_ctrl", ctrl_a, OFFP);
    check("ar_level", level_a, 0);
    check("ar_busy", busy_a, 0);
    check("ar_done", done_a, 0);
    power_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("ar_after_level", level_a, 0);
    check("ar_after_done", done_a, 1);

    // N_STEPS=8, all dwell 0: ON exactly 8 cycles after RAMP_UP entry
    power_b = 1'b1;
    for (int k = 0; k <= NB; k++) begin
      tick();
      check($sformatf("z_level_e%0d", k), level_b, k);
      check($sformatf("z_busy_e%0d", k), busy_b, (k < NB));
      check($sformatf("z_done_e%0d", k), done_b, (k == NB));
    end
    power_b = 1'b0;
    for (int k = 0; k <= NB; k++) tick();
    check("z_down_level", level_b, 0);
    check("z_down_ctrl", ctrl_b, OFFP);

    // randomized requests against the model
    m_level = 0;
    m_dir   = 0;
    m_cnt   = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (m_dir == 0 && $urandom_range(0, 3) == 0) begin
        for (int k = 0; k < NB; k++) begin
          m_dw[k]  = int'($urandom_range(0, 3));
          m_pat[k] = OW'($urandom_range(0, 1023));
          dwell_b[k*CW +: CW]   = CW'(m_dw[k]);
          pattern_b[k*OW +: OW] = m_pat[k];
        end
      end
      if ($urandom_range(0, 11) == 0) power_b = ~power_b;
      tick();
      model_step(power_b);
      check($sformatf("r_level_c%0d", cyc), level_b, m_level);
      check($sformatf("r_ctrl_c%0d", cyc), ctrl_b, (m_level == 0) ? OFFP : m_pat[m_level-1]);
      check($sformatf("r_busy_c%0d", cyc), busy_b, (m_dir != 0));
      check($sformatf("r_done_c%0d", cyc), done_b,
            (m_dir == 0) && ((power_b && m_level == NB) || (!power_b && m_level == 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
